// File: rtl/replay_memory_v3_pkg.sv
// Shared types and constants for the Dyna-Q replay memory.
// Holds field widths, buffer geometry, LFSR polynomial/seed, the action
// encoding, the stored transition record and the sampler state encoding.
package replay_memory_v3_pkg;

  localparam int LOCATION_LENGTH = 8;
  localparam int REWARD_LENGTH   = 11;
  localparam int DEPTH           = 16;
  localparam int ADDR_LENGTH     = $clog2(DEPTH);
  localparam int LFSR_LENGTH     = 16;
  localparam int MAX_TRIES       = 8;

  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
  localparam logic [LFSR_LENGTH-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [LFSR_LENGTH-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ACT_UP    = 2'd0,
    ACT_DOWN  = 2'd1,
    ACT_LEFT  = 2'd2,
    ACT_RIGHT = 2'd3
  } action_t;

  typedef logic        [LOCATION_LENGTH-1:0] loc_t;
  typedef logic signed [REWARD_LENGTH-1:0]   reward_t;
  typedef logic        [ADDR_LENGTH-1:0]     addr_t;
  typedef logic        [ADDR_LENGTH:0]       cnt_t;

  typedef struct packed {
    loc_t    loc;
    action_t act;
    loc_t    nloc;
    reward_t rew;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_READ   = 2'd2
  } samp_state_t;

endpackage

// File: rtl/replay_memory_v3_if.sv
// Bus between the agent / planning datapath and the replay memory.
// master: agent side (drives write strobes, flush, sample requests)
// slave : replay memory (drives sample data, busy/valid, count/full)
interface replay_memory_v3_if;
  import replay_memory_v3_pkg::*;

  logic    w_en;
  loc_t    current_location;
  loc_t    n_location;
  action_t action;
  logic    w_en_2;
  loc_t    next_location;
  reward_t reward;
  logic    flush;
  logic    sample_req;
  logic    sample_busy;
  logic    sample_valid;
  loc_t    sample_location;
  action_t sample_action;
  loc_t    sample_n_location;
  reward_t sample_reward;
  cnt_t    count;
  logic    full;

  modport master (
    output w_en, current_location, n_location, action,
    output w_en_2, next_location, reward, flush, sample_req,
    input  sample_busy, sample_valid, sample_location, sample_action,
    input  sample_n_location, sample_reward, count, full
  );

  modport slave (
    input  w_en, current_location, n_location, action,
    input  w_en_2, next_location, reward, flush, sample_req,
    output sample_busy, sample_valid, sample_location, sample_action,
    output sample_n_location, sample_reward, count, full
  );

endinterface

// File: rtl/replay_memory_v3_lfsr.sv
// Galois LFSR, free running: advances every clock, loads SEED on reset.
// Ports: clk, reset (async, active low), q = low OUT_W bits of the state.
module lfsr_galois #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter int               OUT_W = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  output logic [OUT_W-1:0] q
);

  logic [WIDTH-1:0] state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SEED;
    else        state <= (state >> 1) ^ (state[0] ? TAPS : '0);
  end

  assign q = state[OUT_W-1:0];

endmodule

// File: rtl/replay_memory_v3.sv
// Replay memory: DEPTH-entry circular store of Dyna-Q transitions with an
// LFSR-driven random sampler for the planning loop.
// Ports: clk, reset (async, active low), bus (replay_memory_v3_if.slave).
//  Write: w_en stages (location, action) when the robot moved; w_en_2
//  commits the staged pair with next_location/reward. flush clears contents.
//  Sample: sample_req starts a search; sample_valid pulses with the entry.
module replay_memory_v3
  import replay_memory_v3_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  replay_memory_v3_if.slave   bus
);

  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  typedef logic [TRY_W-1:0] try_t;
  localparam try_t  TRY_LAST   = try_t'(MAX_TRIES - 1);
  localparam try_t  TRY_ONE    = try_t'(1);
  localparam addr_t ADDR_ONE   = addr_t'(1);
  localparam cnt_t  CNT_ONE    = cnt_t'(1);
  localparam cnt_t  COUNT_FULL = cnt_t'(DEPTH);

  // ---------------- write side ----------------
  logic    pending;
  loc_t    stg_loc;
  action_t stg_act;
  addr_t   wr_ptr;
  cnt_t    count_q;
  entry_t  mem [DEPTH];
  entry_t  wr_entry;

  logic stage, commit;
  assign stage  = bus.w_en && (bus.current_location != bus.n_location);
  assign commit = bus.w_en_2 && pending;

  // commit always uses the pair staged before this edge, so a same-cycle
  // stage lands in the registers only after the old pair is written
  assign wr_entry.loc  = stg_loc;
  assign wr_entry.act  = stg_act;
  assign wr_entry.nloc = bus.next_location;
  assign wr_entry.rew  = bus.reward;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      stg_loc <= '0;
      stg_act <= ACT_UP;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      pending <= 1'b0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (commit) begin
        wr_ptr <= wr_ptr + ADDR_ONE;
        if (count_q != COUNT_FULL) count_q <= count_q + CNT_ONE;
      end
      if (stage) begin
        stg_loc <= bus.current_location;
        stg_act <= bus.action;
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  // storage array is intentionally left unreset
  always_ff @(posedge clk) begin
    if (commit && !bus.flush) mem[wr_ptr] <= wr_entry;
  end

  // ---------------- sampler ----------------
  addr_t rnd;

  lfsr_galois #(
    .WIDTH (LFSR_LENGTH),
    .SEED  (LFSR_SEED),
    .TAPS  (LFSR_TAPS),
    .OUT_W (ADDR_LENGTH)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (rnd)
  );

  samp_state_t state, state_n;
  try_t        tries, tries_n;
  addr_t       idx, idx_n;
  entry_t      samp_q;
  logic        samp_vld_q;

  always_comb begin
    state_n = state;
    tries_n = tries;
    idx_n   = idx;
    unique case (state)
      S_IDLE: begin
        if (bus.sample_req && (count_q != '0)) begin
          state_n = S_SEARCH;
          tries_n = '0;
        end
      end
      S_SEARCH: begin
        if ({1'b0, rnd} < count_q) begin
          idx_n   = rnd;
          state_n = S_READ;
        end else if (tries == TRY_LAST) begin
          // give up on random hits; newest entry is always valid
          idx_n   = wr_ptr - ADDR_ONE;
          state_n = S_READ;
        end else begin
          tries_n = tries + TRY_ONE;
        end
      end
      S_READ:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (bus.flush) state_n = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      tries      <= '0;
      idx        <= '0;
      samp_q     <= '0;
      samp_vld_q <= 1'b0;
    end else begin
      state      <= state_n;
      tries      <= tries_n;
      idx        <= idx_n;
      // read sees the array before any same-edge write
      samp_vld_q <= (state == S_READ) && !bus.flush;
      if ((state == S_READ) && !bus.flush) samp_q <= mem[idx];
    end
  end

  assign bus.sample_busy       = (state != S_IDLE);
  assign bus.sample_valid      = samp_vld_q;
  assign bus.sample_location   = samp_q.loc;
  assign bus.sample_action     = samp_q.act;
  assign bus.sample_n_location = samp_q.nloc;
  assign bus.sample_reward     = samp_q.rew;
  assign bus.count             = count_q;
  assign bus.full              = (count_q == COUNT_FULL);

endmodule

// File: tb/tb_replay_memory_v3.sv
// Bench for replay_memory_v3: randomized writes and samples checked against
// a queue model holding the last DEPTH committed transitions.
module tb_replay_memory_v3;
  import replay_memory_v3_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests_run = 0;
  int   fails = 0;

  replay_memory_v3_if bus();
  replay_memory_v3 dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  // reference model: committed transitions oldest..newest plus staged pair
  entry_t  mq[$];
  bit      m_pend = 0;
  loc_t    m_loc;
  action_t m_act;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    bus.w_en = 0; bus.current_location = '0; bus.n_location = '0; bus.action = ACT_UP;
    bus.w_en_2 = 0; bus.next_location = '0; bus.reward = '0;
    bus.flush = 0; bus.sample_req = 0;
  endtask

  task automatic model_clear();
    mq.delete();
    m_pend = 0;
  endtask

  task automatic drive_cycle(input bit we, input loc_t cl, input loc_t nl, input action_t a,
                             input bit we2, input loc_t nx, input reward_t r);
    entry_t e;
    bus.w_en = we; bus.current_location = cl; bus.n_location = nl; bus.action = a;
    bus.w_en_2 = we2; bus.next_location = nx; bus.reward = r;
    tick();
    clear_inputs();
    if (we2 && m_pend) begin
      e.loc = m_loc; e.act = m_act; e.nloc = nx; e.rew = r;
      mq.push_back(e);
      if (mq.size() > DEPTH) void'(mq.pop_front());
      m_pend = 0;
    end
    if (we && cl != nl) begin
      m_loc = cl; m_act = a; m_pend = 1;
    end
  endtask

  task automatic write_tr(input loc_t cl, input loc_t nl, input action_t a,
                          input loc_t nx, input reward_t r);
    drive_cycle(1, cl, nl, a, 0, '0, '0);
    drive_cycle(0, '0, '0, ACT_UP, 1, nx, r);
  endtask

  task automatic do_flush();
    bus.flush = 1;
    tick();
    bus.flush = 0;
    model_clear();
  endtask

  // lat = clock edges from the request edge up to the one raising sample_valid
  task automatic sample_one(output entry_t got, output int lat, output bit seen);
    bus.sample_req = 1;
    tick();
    bus.sample_req = 0;
    lat = 1; seen = 0;
    while (!seen && lat <= MAX_TRIES + 4) begin
      if (bus.sample_valid) seen = 1;
      else begin tick(); lat++; end
    end
    got.loc = bus.sample_location; got.act = bus.sample_action;
    got.nloc = bus.sample_n_location; got.rew = bus.sample_reward;
  endtask

  function automatic int find_in_model(entry_t e);
    foreach (mq[k]) if (mq[k] === e) return k;
    return -1;
  endfunction

  // 1: reset state and a request on an empty buffer
  task automatic test_reset();
    bit vld_seen = 0, busy_seen = 0;
    clear_inputs();
    reset = 0;
    tick(); tick();
    tests_run++; if (bus.count !== '0) begin fails++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    tests_run++; if (bus.full !== 1'b0) begin fails++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    tests_run++; if (bus.sample_valid !== 1'b0 || bus.sample_busy !== 1'b0) begin
      fails++; $display("FAIL reset_flags valid=%b busy=%b exp=0/0", bus.sample_valid, bus.sample_busy); end
    tests_run++; if ({bus.sample_location, bus.sample_reward} !== '0) begin
      fails++; $display("FAIL reset_sample_data loc=%0d rew=%0d exp=0/0", bus.sample_location, bus.sample_reward); end
    #3 reset = 1;
    tick();
    model_clear();
    bus.sample_req = 1;
    tick();
    bus.sample_req = 0;
    for (int i = 0; i < MAX_TRIES + 4; i++) begin
      if (bus.sample_valid) vld_seen = 1;
      if (bus.sample_busy) busy_seen = 1;
      tick();
    end
    tests_run++; if (vld_seen || busy_seen) begin
      fails++; $display("FAIL empty_sample valid_seen=%b busy_seen=%b exp=0/0", vld_seen, busy_seen); end
    tests_run++; if (bus.count !== '0) begin fails++; $display("FAIL empty_count got=%0d exp=0", bus.count); end
  endtask

  // 2: phase-1 filter on unmoved robot, then a real commit
  task automatic test_write_filter();
    write_tr(8'd5, 8'd5, ACT_LEFT, 8'd9, 11'sd7);
    tests_run++; if (bus.count !== cnt_t'(0)) begin fails++; $display("FAIL filter_count got=%0d exp=0", bus.count); end
    write_tr(8'd5, 8'd4, ACT_LEFT, 8'd6, -11'sd3);
    tests_run++; if (bus.count !== cnt_t'(1)) begin fails++; $display("FAIL commit_count got=%0d exp=1", bus.count); end
    // phase 2 with nothing staged must not add an entry
    drive_cycle(0, '0, '0, ACT_UP, 1, 8'd77, 11'sd55);
    tests_run++; if (bus.count !== cnt_t'(mq.size())) begin
      fails++; $display("FAIL orphan_w_en_2 got=%0d exp=%0d", bus.count, mq.size()); end
  endtask

  // 3: single entry sample, latency window, pulse width, hold
  task automatic test_single_sample();
    entry_t got, exp;
    int lat; bit seen;
    exp.loc = 8'd5; exp.act = ACT_LEFT; exp.nloc = 8'd6; exp.rew = -11'sd3;
    sample_one(got, lat, seen);
    tests_run++; if (!seen || lat < 3 || lat > MAX_TRIES + 2) begin
      fails++; $display("FAIL single_latency seen=%b lat=%0d exp=3..%0d", seen, lat, MAX_TRIES + 2); end
    tests_run++; if (got !== exp) begin fails++; $display("FAIL single_data got=%h exp=%h", got, exp); end
    tick();
    tests_run++; if (bus.sample_valid !== 1'b0) begin fails++; $display("FAIL pulse_width valid=%b exp=0", bus.sample_valid); end
    tick(); tick();
    tests_run++; if (bus.sample_location !== 8'd5 || bus.sample_reward !== -11'sd3) begin
      fails++; $display("FAIL sample_hold loc=%0d rew=%0d exp=5/-3", bus.sample_location, bus.sample_reward); end
  endtask

  // 4: wrap past DEPTH, saturated count, sample distribution
  task automatic test_wrap_coverage();
    entry_t got;
    int lat, k; bit seen;
    bit hit [DEPTH];
    do_flush();
    for (int i = 0; i < DEPTH + 3; i++)
      write_tr(loc_t'(i + 10), loc_t'(i + 200), action_t'($urandom_range(0, 3)),
               loc_t'($urandom_range(0, 255)), reward_t'($urandom));
    tests_run++; if (bus.count !== cnt_t'(DEPTH) || bus.full !== 1'b1) begin
      fails++; $display("FAIL wrap_full count=%0d full=%b exp=%0d/1", bus.count, bus.full, DEPTH); end
    foreach (hit[j]) hit[j] = 0;
    for (int s = 0; s < 1000; s++) begin
      sample_one(got, lat, seen);
      k = find_in_model(got);
      // with a full buffer every random index is valid, so the first probe hits
      tests_run++; if (!seen || lat != 3) begin
        fails++; $display("FAIL full_latency s=%0d seen=%b lat=%0d exp=3", s, seen, lat); end
      tests_run++; if (k < 0) begin
        fails++; $display("FAIL sample_member s=%0d got_loc=%0d exp=one of last %0d", s, got.loc, DEPTH); end
      else hit[k] = 1;
    end
    for (int j = 0; j < DEPTH; j++) begin
      tests_run++; if (!hit[j]) begin fails++; $display("FAIL coverage entry=%0d hit=0 exp=1", j); end
    end
  endtask

  // 5: same-cycle commit-then-stage
  task automatic test_same_cycle();
    entry_t got, e3, e7;
    int lat; bit seen, saw3 = 0, saw7 = 0;
    e3.loc = 8'd3; e3.act = ACT_DOWN;  e3.nloc = 8'd20; e3.rew = 11'sd100;
    e7.loc = 8'd7; e7.act = ACT_RIGHT; e7.nloc = 8'd30; e7.rew = -11'sd50;
    do_flush();
    tests_run++; if (bus.count !== '0) begin fails++; $display("FAIL flush_count got=%0d exp=0", bus.count); end
    drive_cycle(1, 8'd3, 8'd2, ACT_DOWN, 0, '0, '0);
    drive_cycle(1, 8'd7, 8'd6, ACT_RIGHT, 1, 8'd20, 11'sd100);
    tests_run++; if (bus.count !== cnt_t'(1)) begin fails++; $display("FAIL same_cycle_count1 got=%0d exp=1", bus.count); end
    drive_cycle(0, '0, '0, ACT_UP, 1, 8'd30, -11'sd50);
    tests_run++; if (bus.count !== cnt_t'(2)) begin fails++; $display("FAIL same_cycle_count2 got=%0d exp=2", bus.count); end
    for (int s = 0; s < 40; s++) begin
      sample_one(got, lat, seen);
      tests_run++; if (!seen || lat < 3 || lat > MAX_TRIES + 2 || (got !== e3 && got !== e7)) begin
        fails++; $display("FAIL same_cycle_sample s=%0d seen=%b lat=%0d got=%h exp=%h or %h", s, seen, lat, got, e3, e7); end
      if (got === e3) saw3 = 1;
      if (got === e7) saw7 = 1;
    end
    tests_run++; if (!saw3 || !saw7) begin fails++; $display("FAIL same_cycle_both saw3=%b saw7=%b exp=1/1", saw3, saw7); end
  endtask

  // 6: flush during SEARCH, async reset during READ
  task automatic test_flush_reset();
    entry_t got;
    int lat; bit seen, vld_seen = 0;
    for (int i = 0; i < DEPTH; i++)
      write_tr(loc_t'($urandom_range(1, 100)), 8'd250, ACT_UP, loc_t'($urandom_range(1, 255)), 11'sd1);
    bus.sample_req = 1;
    tick();
    bus.sample_req = 0;
    tests_run++; if (bus.sample_busy !== 1'b1) begin fails++; $display("FAIL search_busy got=%b exp=1", bus.sample_busy); end
    do_flush();
    for (int i = 0; i < MAX_TRIES + 4; i++) begin
      if (bus.sample_valid) vld_seen = 1;
      tick();
    end
    tests_run++; if (vld_seen || bus.count !== '0 || bus.sample_busy !== 1'b0) begin
      fails++; $display("FAIL flush_search valid_seen=%b count=%0d busy=%b exp=0/0/0", vld_seen, bus.count, bus.sample_busy); end
    for (int i = 0; i < DEPTH; i++)
      write_tr(loc_t'($urandom_range(1, 100)), 8'd250, ACT_UP, loc_t'($urandom_range(1, 255)), 11'sd1);
    sample_one(got, lat, seen);
    bus.sample_req = 1;
    tick();                       // request edge -> SEARCH
    bus.sample_req = 0;
    tick();                       // full buffer: first probe hits -> READ
    tests_run++; if (bus.sample_busy !== 1'b1) begin fails++; $display("FAIL read_busy got=%b exp=1", bus.sample_busy); end
    #2 reset = 0;
    #1;
    model_clear();
    tests_run++; if (bus.sample_valid !== 1'b0 || bus.sample_busy !== 1'b0 || bus.count !== '0 || bus.full !== 1'b0) begin
      fails++; $display("FAIL async_reset_flags valid=%b busy=%b count=%0d full=%b exp=0", bus.sample_valid, bus.sample_busy, bus.count, bus.full); end
    tests_run++; if ({bus.sample_location, bus.sample_n_location, bus.sample_reward} !== '0) begin
      fails++; $display("FAIL async_reset_data loc=%0d nloc=%0d rew=%0d exp=0", bus.sample_location, bus.sample_n_location, bus.sample_reward); end
    #1 reset = 1;
    vld_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.sample_valid) vld_seen = 1;
    end
    tests_run++; if (vld_seen || bus.count !== '0) begin
      fails++; $display("FAIL post_reset valid_seen=%b count=%0d exp=0/0", vld_seen, bus.count); end
  endtask

  initial begin
    test_reset();
    test_write_filter();
    test_single_sample();
    test_wrap_coverage();
    test_same_cycle();
    test_flush_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
